maple_rx: RTL and testbench

- Maple bus receiver/decoder that sits directly upstream of the USB FIFO writer.
- Samples the two-wire bus (SDCKA/SDCKB), detects the start and end patterns, deserialises the data bits into bytes, and presents them on the menable/mready/mdata master interface consumed by the FIFO writer.
- Also flags malformed or stalled frames.

---
 rtl/maple_pkg.sv | 18 +
 rtl/maple_sync_edge.sv | 32 +++
 rtl/maple_rx.sv | 157 +++++++++++++++
 tb/tb_maple_rx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared constants for the Maple bus receiver: one-hot FSM states,
// start/end pattern pulse counts and byte geometry.
package maple_pkg;

    localparam int BYTE_W         = 8;
    localparam int BIT_W          = $clog2(BYTE_W);
    localparam int START_B_PULSES = 4;
    localparam int END_A_PULSES   = 2;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        END   = 5'b01000,
        ERR   = 5'b10000
    } state_t;

endpackage

// File: rtl/maple_sync_edge.sv
// 2-FF synchroniser for one Maple line plus registered rise/fall pulses.
// level is delayed one stage so it is cycle-aligned with the pulses.
module maple_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    // Resets to the idle bus level so releasing reset on a quiet bus makes no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= line;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/maple_rx.sv
// Maple bus receiver: decodes start/data/end patterns into bytes on menable/mready/mdata.
// Optional frame checksum check is built when MAPLE_RX_CRC_EN is defined.
module maple_rx
    import maple_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 480,
    parameter int TMO_W          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdcka,
    input  logic              sdckb,
    output logic              menable,
    output logic              mready,
    output logic [BYTE_W-1:0] mdata,
    output logic              frame_err,
    output logic [15:0]       byte_cnt,
    output logic              crc_err
);

    logic a_s, a_rise, a_fall;
    logic b_s, b_rise, b_fall;

    maple_sync_edge u_sync_a (
        .clk   (clk),
        .reset (reset),
        .line  (sdcka),
        .level (a_s),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    maple_sync_edge u_sync_b (
        .clk   (clk),
        .reset (reset),
        .line  (sdckb),
        .level (b_s),
        .rise  (b_rise),
        .fall  (b_fall)
    );

    state_t            state;
    state_t            state_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [2:0]        pulse_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              phase_b;
    logic [BYTE_W-2:0] shift_reg;

    logic              tmo_hit;
    logic              any_edge;
    logic              in_frame;
    logic              bit_in;
    logic              shift_take;
    logic              byte_done;
    logic [BYTE_W-1:0] byte_now;

    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    assign any_edge  = a_rise | a_fall | b_rise | b_fall;
    assign in_frame  = (state == START) || (state == DATA) || (state == END);
    assign bit_in    = phase_b ? a_s : b_s;
    assign byte_now  = {shift_reg, bit_in};
    assign menable   = (state == DATA) || (state == END);
    assign frame_err = (state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (a_fall && b_s) state_next = START;
            START: begin
                if (tmo_hit)     state_next = ERR;
                else if (a_rise) state_next = (pulse_cnt == 3'(START_B_PULSES)) ? DATA : ERR;
            end
            DATA: begin
                // The clock line alternates A/B; a fall on the other line is only legal as the end marker.
                if (tmo_hit)                 state_next = ERR;
                else if (a_fall && b_fall)   state_next = ERR;
                else if (!phase_b && b_fall) state_next = (bit_cnt == '0) ? END : ERR;
                else if (phase_b && a_fall)  state_next = ERR;
            end
            END: begin
                if (tmo_hit)     state_next = ERR;
                else if (b_rise) state_next = (pulse_cnt == 3'(END_A_PULSES)) ? IDLE : ERR;
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign shift_take = (state == DATA) && (state_next == DATA) && (phase_b ? b_fall : a_fall);
    assign byte_done  = shift_take && (bit_cnt == BIT_W'(BYTE_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            phase_b   <= 1'b0;
            shift_reg <= '0;
            mready    <= 1'b0;
            mdata     <= '0;
            byte_cnt  <= '0;
        end else begin
            mready <= 1'b0;

            if (!in_frame || any_edge) tmo_cnt <= '0;
            else if (!tmo_hit)         tmo_cnt <= tmo_cnt + 1'b1;

            if ((state == IDLE && state_next == START) || (state == DATA && state_next == END))
                pulse_cnt <= '0;
            else if (pulse_cnt != 3'd7 &&
                     ((state == START && b_fall && !a_s) || (state == END && a_fall && !b_s)))
                pulse_cnt <= pulse_cnt + 3'd1;

            if (state == START && state_next == DATA) begin
                phase_b  <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (shift_take) begin
                shift_reg <= byte_now[BYTE_W-2:0];
                phase_b   <= ~phase_b;
                bit_cnt   <= bit_cnt + 1'b1;
                if (byte_done) begin
                    mdata  <= byte_now;
                    mready <= 1'b1;
                    if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                end
            end
        end
    end

`ifdef MAPLE_RX_CRC_EN
    logic [BYTE_W-1:0] xor_acc;

    // The last byte of a frame is the checksum, so a good frame XORs to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_acc <= '0;
            crc_err <= 1'b0;
        end else begin
            if (state == START && state_next == DATA) xor_acc <= '0;
            else if (byte_done)                       xor_acc <= xor_acc ^ byte_now;

            if (state == END && state_next == IDLE) crc_err <= |xor_acc;
            else if (state == ERR)                  crc_err <= 1'b0;
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_maple_rx.sv
// Self-checking bench for maple_rx: drives Maple bus waveforms, scoreboards received bytes.
module tb_maple_rx;

    localparam int HOLD = 6;

`ifdef MAPLE_RX_CRC_EN
    localparam logic CRC_BAD_EXP = 1'b1;
`else
    localparam logic CRC_BAD_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sdcka;
    logic        sdckb;
    logic        menable;
    logic        mready;
    logic [7:0]  mdata;
    logic        frame_err;
    logic [15:0] byte_cnt;
    logic        crc_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    int   mready_cnt = 0;
    int   ferr_cnt   = 0;
    int   en_cnt     = 0;
    int   long_cnt   = 0;
    logic mready_d   = 1'b0;

    maple_rx dut (
        .clk       (clk),
        .reset     (reset),
        .sdcka     (sdcka),
        .sdckb     (sdckb),
        .menable   (menable),
        .mready    (mready),
        .mdata     (mdata),
        .frame_err (frame_err),
        .byte_cnt  (byte_cnt),
        .crc_err   (crc_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // output monitor: records bytes and pulse counts at the inactive edge
    always @(negedge clk) begin
        if (mready) begin
            obs_q.push_back(mdata);
            mready_cnt <= mready_cnt + 1;
        end
        if (mready && mready_d) long_cnt <= long_cnt + 1;
        mready_d <= mready;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (menable) en_cnt <= en_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive(input logic na, input logic nb);
        sdcka = na;
        sdckb = nb;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic send_start(input int pulses);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        for (int i = 0; i < pulses; i++) begin
            drive(1'b0, 1'b0);
            if (i != pulses - 1) drive(1'b0, 1'b1);
        end
        drive(1'b1, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] value, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            d = value[7 - i];
            if (i % 2 == 0) begin
                drive(1'b1, d);
                drive(1'b0, d);
            end else begin
                drive(d, 1'b1);
                drive(d, 1'b0);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] value);
        exp_q.push_back(value);
        send_bits(value, 8);
    endtask

    task automatic send_end();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0);
            drive(1'b1, 1'b0);
        end
        drive(1'b1, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_start(4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_end();
        repeat (4) @(negedge clk);
    endtask

    // scoreboard
    task automatic check_sb(input string name);
        logic [7:0] e;
        logic [7:0] g;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s: byte missing, expected 0x%02h", name, e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s: mdata got 0x%02h expected 0x%02h", name, g, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d unexpected byte(s), first 0x%02h", name, obs_q.size(), obs_q[0]);
            obs_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sdcka = 1'b1;
        sdckb = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (menable !== 1'b0)   begin errors++; $display("FAIL reset_menable: got %b expected 0", menable); end
        checks++; if (mready !== 1'b0)    begin errors++; $display("FAIL reset_mready: got %b expected 0", mready); end
        checks++; if (mdata !== 8'h00)    begin errors++; $display("FAIL reset_mdata: got 0x%02h expected 0x00", mdata); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (crc_err !== 1'b0)   begin errors++; $display("FAIL reset_crc_err: got %b expected 0", crc_err); end
        @(posedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_good_frame();
        int m0, f0;
        m0 = mready_cnt;
        f0 = ferr_cnt;
        send_start(4);
        @(negedge clk);
        checks++; if (menable !== 1'b1) begin errors++; $display("FAIL good_menable_start: got %b expected 1", menable); end
        send_byte(8'hA5);
        @(negedge clk);
        checks++; if (menable !== 1'b1) begin errors++; $display("FAIL good_menable_byte1: got %b expected 1", menable); end
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL good_byte_cnt1: got %0d expected 1", byte_cnt); end
        send_byte(8'h3C);
        @(negedge clk);
        checks++; if (menable !== 1'b1) begin errors++; $display("FAIL good_menable_byte2: got %b expected 1", menable); end
        send_end();
        repeat (4) @(negedge clk);
        checks++; if (menable !== 1'b0) begin errors++; $display("FAIL good_menable_end: got %b expected 0", menable); end
        checks++; if (byte_cnt !== 16'd2) begin errors++; $display("FAIL good_byte_cnt: got %0d expected 2", byte_cnt); end
        checks++; if (mdata !== 8'h3C) begin errors++; $display("FAIL good_mdata_hold: got 0x%02h expected 0x3c", mdata); end
        checks++; if (mready_cnt - m0 != 2) begin errors++; $display("FAIL good_mready_count: got %0d expected 2", mready_cnt - m0); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL good_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        checks++; if (long_cnt != 0) begin errors++; $display("FAIL good_mready_width: got %0d long pulses expected 0", long_cnt); end
        check_sb("good_frame");
    endtask

    task automatic test_bad_start();
        int m0, f0, e0;
        m0 = mready_cnt;
        f0 = ferr_cnt;
        e0 = en_cnt;
        send_start(3);
        drive(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL bad_start_frame_err: got %0d pulses expected 1", ferr_cnt - f0); end
        checks++; if (en_cnt != e0) begin errors++; $display("FAIL bad_start_menable: high %0d cycles expected 0", en_cnt - e0); end
        checks++; if (byte_cnt !== 16'd2) begin errors++; $display("FAIL bad_start_byte_cnt: got %0d expected 2", byte_cnt); end
        checks++; if (mready_cnt != m0) begin errors++; $display("FAIL bad_start_mready: got %0d expected 0", mready_cnt - m0); end
    endtask

    task automatic test_partial_byte();
        int m0, f0;
        m0 = mready_cnt;
        f0 = ferr_cnt;
        send_start(4);
        send_bits(8'hB0, 5);
        send_end();
        repeat (4) @(negedge clk);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL partial_frame_err: got %0d pulses expected 1", ferr_cnt - f0); end
        checks++; if (mready_cnt != m0) begin errors++; $display("FAIL partial_mready: got %0d expected 0", mready_cnt - m0); end
        checks++; if (menable !== 1'b0) begin errors++; $display("FAIL partial_menable: got %b expected 0", menable); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL partial_byte_cnt: got %0d expected 0", byte_cnt); end
        check_sb("partial");
    endtask

    task automatic test_timeout();
        int f0;
        int cyc;
        bit seen;
        f0 = ferr_cnt;
        send_start(4);
        send_byte(8'h5A);
        cyc  = HOLD;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_seen: frame_err absent after %0d cycles, expected near 485", cyc);
        end else if (cyc < 481 || cyc > 490) begin
            errors++;
            $display("FAIL timeout_latency: frame_err at cycle %0d expected 481..490", cyc);
        end
        checks++; if (menable !== 1'b0) begin errors++; $display("FAIL timeout_menable: got %b expected 0", menable); end
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL timeout_byte_cnt: got %0d expected 1", byte_cnt); end
        drive(1'b1, 1'b1);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL timeout_frame_err: got %0d pulses expected 1", ferr_cnt - f0); end
        check_sb("timeout");
    endtask

    task automatic test_reset_mid_frame();
        int m0, f0;
        send_start(4);
        send_byte(8'h77);
        send_bits(8'hFF, 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (menable !== 1'b0 || mready !== 1'b0 || mdata !== 8'h00 ||
            frame_err !== 1'b0 || byte_cnt !== 16'd0 || crc_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got en=%b rdy=%b data=0x%02h ferr=%b cnt=%0d crc=%b expected all 0",
                     menable, mready, mdata, frame_err, byte_cnt, crc_err);
        end
        check_sb("midreset_pre");
        sdcka = 1'b1;
        sdckb = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        m0 = mready_cnt;
        f0 = ferr_cnt;
        send_frame(8'h01, 8'h02, 8'h03);
        checks++; if (mready_cnt - m0 != 3) begin errors++; $display("FAIL midreset_mready: got %0d expected 3", mready_cnt - m0); end
        checks++; if (byte_cnt !== 16'd3) begin errors++; $display("FAIL midreset_byte_cnt: got %0d expected 3", byte_cnt); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL midreset_frame_err: got %0d expected 0", ferr_cnt - f0); end
        check_sb("midreset_frame");
    endtask

    task automatic test_crc();
        send_frame(8'h12, 8'h34, 8'h26);
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL crc_good: got %b expected 0", crc_err); end
        send_frame(8'h12, 8'h34, 8'h27);
        checks++; if (crc_err !== CRC_BAD_EXP) begin errors++; $display("FAIL crc_bad: got %b expected %b", crc_err, CRC_BAD_EXP); end
        check_sb("crc_frames");
        send_start(2);
        drive(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL crc_err_clear: got %b expected 0", crc_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v0, v1, v2;
        for (int k = 0; k < 3; k++) begin
            v0 = 8'($urandom_range(0, 255));
            v1 = 8'($urandom_range(0, 255));
            v2 = v0 ^ v1;
            send_frame(v0, v1, v2);
            checks++; if (byte_cnt !== 16'd3) begin errors++; $display("FAIL b2b_byte_cnt: got %0d expected 3", byte_cnt); end
            checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL b2b_crc: got %b expected 0", crc_err); end
        end
        check_sb("back_to_back");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_start();
        test_partial_byte();
        test_timeout();
        test_reset_mid_frame();
        test_crc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
